wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
// PURPOSE
//   Two-master/one-slave Wishbone classic arbiter sharing one memory port between
//   the instruction-fetch port (i*) and the load/store data port (d*) of the core.
//   Round-robin grant, grant held for a whole cycle (cyc high), bus-timeout watchdog
//   that returns an error to a stuck master. Sits between core and memory/interconnect.
// PARAMETERS
//   TIMEOUT_CYCLES  16  cycles of stb high with no ack/err before watchdog error (>=2)
//   RESET_PRIO_I     1  1: I wins first tie after reset; 0: D wins
// PORTS
//   clk        in   1   system clock, all logic on rising edge
//   rst        in   1   asynchronous active-low reset
//   iaddr_i    in  32   I-master address;  idat_i in 32 write data; isel_i in 4 byte sel
//   icyc_i     in   1   I-master cycle;    istb_i in 1 strobe;      iwe_i  in 1 write enable
//   idat_o     out 32   read data to I;    iack_o out 1 ack;        ierr_o out 1 error
//   daddr_i    in  32   D-master address;  ddat_i in 32;  dsel_i in 4
//   dcyc_i     in   1   D-master cycle;    dstb_i in 1;   dwe_i  in 1
//   ddat_o     out 32   read data to D;    dack_o out 1;  derr_o out 1
//   wbaddr_o   out 32   slave address;     wbdat_o out 32; wbsel_o out 4
//   wbcyc_o    out  1   slave cycle;       wbstb_o out 1;  wbwe_o  out 1
//   wbdat_i    in  32   slave read data;   wback_i in 1;   wberr_i in 1
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, last_grant = RESET_PRIO_I ? D : I, tmo_cnt=0;
//     wbcyc_o/wbstb_o/wbwe_o=0, wbaddr_o/wbdat_o/wbsel_o=0, all ack/err outputs=0.
//     Mid-transfer reset drops wbcyc_o at once; no ack/err emitted for that transfer.
//   FSM IDLE / GNT_I / GNT_D, registered:
//     IDLE: req_x = xcyc_i & xstb_i. Single request -> GNT_x. Both -> grant the master
//       NOT equal to last_grant. last_grant updated on entry to GNT_x. None -> IDLE.
//     GNT_x: stays while xcyc_i=1; xcyc_i=0 -> IDLE (one dead cycle between grants).
//       Watchdog fire -> IDLE.
//   Latency: request in cycle N -> wbcyc_o/wbstb_o high in cycle N+1 (grant registered).
//   Slave-side mux (combinational from state): GNT_x drives wbaddr/wbdat/wbsel/wbwe
//     from master x, wbcyc_o=xcyc_i, wbstb_o=xstb_i; IDLE drives all zero.
//   Return path (combinational): idat_o=ddat_o=wbdat_i; xack_o=wback_i & GNT_x;
//     xerr_o=(wberr_i | tmo_fire) & GNT_x. Non-granted master never sees ack/err.
//   Multi-beat: master may keep cyc high and issue further stb beats; grant is not
//     re-arbitrated until cyc drops (no preemption, other master waits indefinitely).
//   Watchdog: tmo_cnt width $clog2(TIMEOUT_CYCLES+1); cleared in IDLE and on any
//     wback_i|wberr_i; increments each GNT cycle with wbstb_o=1 and no ack/err.
//     tmo_fire = (tmo_cnt == TIMEOUT_CYCLES-1) & wbstb_o & ~wback_i & ~wberr_i:
//     one-cycle xerr_o pulse; next cycle FSM=IDLE, wbcyc_o=0, tmo_cnt=0.
//     If master keeps cyc high it re-enters arbitration normally.
//   Simultaneous wback_i & wberr_i: both forwarded; master treats err as dominant.
//   Ack while stb low (spurious): forwarded as gated above; counter cleared.
// TESTING
//   1 I only, read 0x0000_0100, slave acks 2 cycles after wbstb_o with 0x0000_0013
//     -> wbcyc_o rises cycle N+1, iack_o 1-cycle pulse with idat_o=0x13, dack_o=0.
//   2 Post-reset I and D request same cycle -> GNT_I first; after icyc_i drop, one
//     IDLE cycle, then GNT_D; next tie -> I granted (round robin alternates).
//   3 D write 0xDEAD_BEEF sel=4'b0011 granted; I requests mid-transfer -> wbaddr_o/
//     wbdat_o/wbsel_o track D only, iack_o=0 until D releases and I granted.
//   4 TIMEOUT_CYCLES=16, slave never acks D -> derr_o pulses on 16th stb cycle,
//     wbcyc_o=0 following cycle, no iack_o/ierr_o activity.
//   5 wberr_i asserted during GNT_I -> ierr_o same cycle, derr_o=0, watchdog cleared.
//   6 rst low while GNT_D with stb high -> wbcyc_o=0 immediately, all acks 0;
//     after rst high and I request -> normal grant with reset priority (I).

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter for the core's fetch (i) and load/store (d) ports.
// Round-robin grant held for a whole cyc, plus a watchdog that errors out a stalled transfer.
module wb_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit RESET_PRIO_I   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iaddr_i,
    input  logic [31:0] idat_i,
    input  logic [3:0]  isel_i,
    input  logic        icyc_i,
    input  logic        istb_i,
    input  logic        iwe_i,
    output logic [31:0] idat_o,
    output logic        iack_o,
    output logic        ierr_o,
    input  logic [31:0] daddr_i,
    input  logic [31:0] ddat_i,
    input  logic [3:0]  dsel_i,
    input  logic        dcyc_i,
    input  logic        dstb_i,
    input  logic        dwe_i,
    output logic [31:0] ddat_o,
    output logic        dack_o,
    output logic        derr_o,
    output logic [31:0] wbaddr_o,
    output logic [31:0] wbdat_o,
    output logic [3:0]  wbsel_o,
    output logic        wbcyc_o,
    output logic        wbstb_o,
    output logic        wbwe_o,
    input  logic [31:0] wbdat_i,
    input  logic        wback_i,
    input  logic        wberr_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          last_i;
    logic          last_i_next;
    logic [CW-1:0] tmo_cnt;
    logic [CW-1:0] tmo_next;
    logic          req_i;
    logic          req_d;
    logic          tmo_fire;

    assign req_i = icyc_i & istb_i;
    assign req_d = dcyc_i & dstb_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            last_i  <= ~RESET_PRIO_I;
            tmo_cnt <= '0;
        end else begin
            state   <= state_next;
            last_i  <= last_i_next;
            tmo_cnt <= tmo_next;
        end
    end

    // Slave side follows the granted master; IDLE parks the bus at zero.
    always_comb begin
        wbaddr_o = '0;
        wbdat_o  = '0;
        wbsel_o  = '0;
        wbcyc_o  = 1'b0;
        wbstb_o  = 1'b0;
        wbwe_o   = 1'b0;
        case (state)
            GNT_I: begin
                wbaddr_o = iaddr_i;
                wbdat_o  = idat_i;
                wbsel_o  = isel_i;
                wbcyc_o  = icyc_i;
                wbstb_o  = istb_i;
                wbwe_o   = iwe_i;
            end
            GNT_D: begin
                wbaddr_o = daddr_i;
                wbdat_o  = ddat_i;
                wbsel_o  = dsel_i;
                wbcyc_o  = dcyc_i;
                wbstb_o  = dstb_i;
                wbwe_o   = dwe_i;
            end
            default: ;
        endcase
    end

    assign tmo_fire = (tmo_cnt == TMO_LAST) & wbstb_o & ~wback_i & ~wberr_i;

    assign idat_o = wbdat_i;
    assign ddat_o = wbdat_i;
    assign iack_o = wback_i & (state == GNT_I);
    assign dack_o = wback_i & (state == GNT_D);
    assign ierr_o = (wberr_i | tmo_fire) & (state == GNT_I);
    assign derr_o = (wberr_i | tmo_fire) & (state == GNT_D);

    // Watchdog counts stalled strobe cycles; any slave response restarts it.
    always_comb begin
        tmo_next = tmo_cnt;
        if (state == IDLE || wback_i || wberr_i || tmo_fire) begin
            tmo_next = '0;
        end else if (wbstb_o) begin
            tmo_next = tmo_cnt + CW'(1);
        end
    end

    // On a tie the master that did not win last time gets the bus.
    always_comb begin
        state_next  = state;
        last_i_next = last_i;
        case (state)
            IDLE: begin
                if (req_i && (!req_d || !last_i)) begin
                    state_next  = GNT_I;
                    last_i_next = 1'b1;
                end else if (req_d) begin
                    state_next  = GNT_D;
                    last_i_next = 1'b0;
                end
            end
            GNT_I: if (tmo_fire || !icyc_i) state_next = IDLE;
            GNT_D: if (tmo_fire || !dcyc_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: inputs change just after the falling edge, outputs are sampled 1 time unit later.
module tb_wb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iaddr_i, idat_i, daddr_i, ddat_i, wbdat_i;
    logic [3:0]  isel_i, dsel_i;
    logic        icyc_i, istb_i, iwe_i, dcyc_i, dstb_i, dwe_i, wback_i, wberr_i;
    logic [31:0] idat_o, ddat_o, wbaddr_o, wbdat_o;
    logic [3:0]  wbsel_o;
    logic        iack_o, ierr_o, dack_o, derr_o, wbcyc_o, wbstb_o, wbwe_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.TIMEOUT_CYCLES(16), .RESET_PRIO_I(1'b1)) dut (
        .clk(clk), .rst(rst),
        .iaddr_i(iaddr_i), .idat_i(idat_i), .isel_i(isel_i),
        .icyc_i(icyc_i), .istb_i(istb_i), .iwe_i(iwe_i),
        .idat_o(idat_o), .iack_o(iack_o), .ierr_o(ierr_o),
        .daddr_i(daddr_i), .ddat_i(ddat_i), .dsel_i(dsel_i),
        .dcyc_i(dcyc_i), .dstb_i(dstb_i), .dwe_i(dwe_i),
        .ddat_o(ddat_o), .dack_o(dack_o), .derr_o(derr_o),
        .wbaddr_o(wbaddr_o), .wbdat_o(wbdat_o), .wbsel_o(wbsel_o),
        .wbcyc_o(wbcyc_o), .wbstb_o(wbstb_o), .wbwe_o(wbwe_o),
        .wbdat_i(wbdat_i), .wback_i(wback_i), .wberr_i(wberr_i)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        iaddr_i = '0; idat_i = '0; isel_i = '0; icyc_i = 0; istb_i = 0; iwe_i = 0;
        daddr_i = '0; ddat_i = '0; dsel_i = '0; dcyc_i = 0; dstb_i = 0; dwe_i = 0;
        wbdat_i = '0; wback_i = 0; wberr_i = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        icyc_i = 1; istb_i = 1; iaddr_i = 32'h0000_00AA; wback_i = 1; wberr_i = 1;
        #12;
        check_output("rst_wbcyc", wbcyc_o, 0);
        check_output("rst_wbstb", wbstb_o, 0);
        check_output("rst_wbaddr", wbaddr_o, 0);
        check_output("rst_iack", iack_o, 0);
        check_output("rst_ierr", ierr_o, 0);
        check_output("rst_derr", derr_o, 0);
        @(negedge clk); clear_inputs(); rst = 1'b1;

        // I-only read with a two-cycle slave
        @(negedge clk); icyc_i = 1; istb_i = 1; iaddr_i = 32'h0000_0100; isel_i = 4'hF;
        #1 check_output("t1_lat_n", wbcyc_o, 0);
        @(negedge clk); #1;
        check_output("t1_wbcyc", wbcyc_o, 1);
        check_output("t1_wbstb", wbstb_o, 1);
        check_output("t1_wbaddr", wbaddr_o, 32'h0000_0100);
        check_output("t1_iack_early", iack_o, 0);
        @(negedge clk); #1 check_output("t1_iack_wait", iack_o, 0);
        @(negedge clk); wback_i = 1; wbdat_i = 32'h0000_0013;
        #1;
        check_output("t1_iack", iack_o, 1);
        check_output("t1_idat", idat_o, 32'h0000_0013);
        check_output("t1_dack", dack_o, 0);
        @(negedge clk); clear_inputs();
        #1;
        check_output("t1_iack_end", iack_o, 0);
        check_output("t1_wbcyc_end", wbcyc_o, 0);

        // Tie after reset goes to I, then D, then I again
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        icyc_i = 1; istb_i = 1; iaddr_i = 32'h0000_1000;
        dcyc_i = 1; dstb_i = 1; daddr_i = 32'h0000_2000;
        #1 check_output("t2_idle", wbcyc_o, 0);
        @(negedge clk); #1;
        check_output("t2_first_i", wbaddr_o, 32'h0000_1000);
        check_output("t2_first_cyc", wbcyc_o, 1);
        @(negedge clk); wback_i = 1;
        #1;
        check_output("t2_iack", iack_o, 1);
        check_output("t2_dack0", dack_o, 0);
        @(negedge clk); wback_i = 0; icyc_i = 0; istb_i = 0;
        #1 check_output("t2_drop", wbcyc_o, 0);
        @(negedge clk); #1 check_output("t2_dead", wbcyc_o, 0);
        @(negedge clk); #1;
        check_output("t2_then_d", wbaddr_o, 32'h0000_2000);
        check_output("t2_d_cyc", wbcyc_o, 1);
        @(negedge clk); wback_i = 1;
        #1;
        check_output("t2_dack", dack_o, 1);
        check_output("t2_iack0", iack_o, 0);
        @(negedge clk); wback_i = 0; dcyc_i = 0; dstb_i = 0;
        @(negedge clk); icyc_i = 1; istb_i = 1; dcyc_i = 1; dstb_i = 1;
        @(negedge clk); #1 check_output("t2_rr_i", wbaddr_o, 32'h0000_1000);
        @(negedge clk); wback_i = 1;
        @(negedge clk); clear_inputs();
        @(negedge clk);

        // D write with I knocking mid-transfer
        dcyc_i = 1; dstb_i = 1; dwe_i = 1; daddr_i = 32'h0000_3000;
        ddat_i = 32'hDEAD_BEEF; dsel_i = 4'b0011;
        @(negedge clk);
        icyc_i = 1; istb_i = 1; iaddr_i = 32'h0000_4000; idat_i = 32'h1234_5678; isel_i = 4'hF;
        #1;
        check_output("t3_addr", wbaddr_o, 32'h0000_3000);
        check_output("t3_dat", wbdat_o, 32'hDEAD_BEEF);
        check_output("t3_sel", wbsel_o, 4'b0011);
        check_output("t3_we", wbwe_o, 1);
        check_output("t3_iack_hold", iack_o, 0);
        @(negedge clk); wback_i = 1;
        #1;
        check_output("t3_dack", dack_o, 1);
        check_output("t3_iack_blk", iack_o, 0);
        check_output("t3_addr2", wbaddr_o, 32'h0000_3000);
        @(negedge clk); wback_i = 0; dcyc_i = 0; dstb_i = 0; dwe_i = 0;
        #1 check_output("t3_drop", wbcyc_o, 0);
        @(negedge clk); #1 check_output("t3_dead", wbcyc_o, 0);
        @(negedge clk); #1;
        check_output("t3_i_addr", wbaddr_o, 32'h0000_4000);
        check_output("t3_i_dat", wbdat_o, 32'h1234_5678);
        check_output("t3_i_we", wbwe_o, 0);
        check_output("t3_i_sel", wbsel_o, 4'hF);
        @(negedge clk); wback_i = 1;
        #1 check_output("t3_iack", iack_o, 1);
        @(negedge clk); clear_inputs();
        @(negedge clk);

        // D stalls forever: watchdog fires on the 16th strobe cycle
        dcyc_i = 1; dstb_i = 1; daddr_i = 32'h0000_5000;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk); #1;
            check_output($sformatf("t4_derr_%0d", k), derr_o, 32'(k == 16));
            check_output($sformatf("t4_ierr_%0d", k), ierr_o, 0);
            check_output($sformatf("t4_iack_%0d", k), iack_o, 0);
        end
        @(negedge clk); #1;
        check_output("t4_cyc_after", wbcyc_o, 0);
        check_output("t4_derr_after", derr_o, 0);
        dcyc_i = 0; dstb_i = 0;
        @(negedge clk); #1 check_output("t4_idle", wbcyc_o, 0);

        // Slave error on I restarts the watchdog
        icyc_i = 1; istb_i = 1; iaddr_i = 32'h0000_6000;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); #1 check_output($sformatf("t5_pre_%0d", k), ierr_o, 0);
        end
        @(negedge clk); wberr_i = 1;
        #1;
        check_output("t5_ierr", ierr_o, 1);
        check_output("t5_derr", derr_o, 0);
        check_output("t5_iack", iack_o, 0);
        for (int k = 12; k <= 27; k++) begin
            @(negedge clk); wberr_i = 0;
            #1 check_output($sformatf("t5_wd_%0d", k), ierr_o, 32'(k == 27));
        end
        @(negedge clk); clear_inputs();
        @(negedge clk);

        // Reset in the middle of a D transfer
        dcyc_i = 1; dstb_i = 1; daddr_i = 32'h0000_7000;
        @(negedge clk); #1 check_output("t6_gnt_d", wbcyc_o, 1);
        #1 rst = 1'b0; wback_i = 1;
        #1;
        check_output("t6_cyc", wbcyc_o, 0);
        check_output("t6_stb", wbstb_o, 0);
        check_output("t6_addr", wbaddr_o, 0);
        check_output("t6_dack", dack_o, 0);
        check_output("t6_derr", derr_o, 0);
        check_output("t6_iack", iack_o, 0);
        @(negedge clk); clear_inputs(); rst = 1'b1;
        icyc_i = 1; istb_i = 1; iaddr_i = 32'h0000_8000;
        dcyc_i = 1; dstb_i = 1; daddr_i = 32'h0000_9000;
        #1 check_output("t6_idle", wbcyc_o, 0);
        @(negedge clk); #1;
        check_output("t6_prio_i", wbaddr_o, 32'h0000_8000);
        check_output("t6_cyc_on", wbcyc_o, 1);
        @(negedge clk); clear_inputs();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
